cmul_pipe: RTL and testbench
============================

Name: cmul_pipe

Overview:
Pipelined, parametrised complex multiplier for the radix-4 FFT datapath. It computes (X+jY)·(L+jM) in fixed point using three real multipliers (Gauss form). It adds a valid/ready handshake, selectable conjugate mode for the IFFT, configurable fractional scaling, rounding, saturation and an overflow flag. It sits between the butterfly output and the twiddle ROM: X/Y carry data and L/M carry the twiddle.

Parameters:
DATA_W, 16, width of every input and output component (signed two's complement).
FRAC_W, 15, number of fractional bits in L/M; the product is shifted right by FRAC_W. Legal range is 1..DATA_W.
ROUND, 1, 1 = round half up (add 2^(FRAC_W-1) before the shift); 0 = truncate toward −inf.
SAT, 1, 1 = saturate to the DATA_W range; 0 = wrap (keep the low DATA_W bits).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
conj  in  1  1 = multiply by conj(L+jM); sampled with the beat
x_re  in  DATA_W  data real (X)
x_im  in  DATA_W  data imag (Y)
w_re  in  DATA_W  twiddle real (L)
w_im  in  DATA_W  twiddle imag (M)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
y_re  out  DATA_W  result real
y_im  out  DATA_W  result imag
ovf  out  1  qualified by out_valid; 1 if either component saturated or wrapped

Behaviour:
- Reset is one clock; asynchronous active-low reset (clk, rst_n). While rst_n=0, all stage valids, out_valid, ovf, y_re and y_im are 0. in_ready is 1 immediately after reset release.
- Enable: en = ~out_valid | out_ready. All pipeline registers load only when en=1. in_ready = en (combinational).
- A beat is accepted when in_valid & in_ready. Stall is global: internal bubbles are not compressed.
- Latency is 3 cycles from acceptance to out_valid when no stall occurs. Throughput is 1 beat/cycle.
- S1 (pre-add):
  - Sign-extend all inputs to DATA_W+1 bits.
  - Mc = conj ? −M : M. Negation happens in DATA_W+1 bits, so M = −2^(DATA_W−1) is exact.
  - Register X, Y, L, d0 = Mc... specifically register X, Y, L, Lm = L−Mc, Lp = L+Mc, Xy = X−Y.
  - Internal width is DATA_W+2 bits.
- S2 (multiply): register t1 = Lm·Y, t2 = Lp·X, t3 = L·Xy, each 2·DATA_W+4 bits, full precision.
- S3 (post-add/scale):
  - re = t1+t3 and im = t2−t3, each 2·DATA_W+5 bits.
  - Optional rounding constant is added, then arithmetic shift right by FRAC_W.
  - Saturate to [−2^(DATA_W−1), 2^(DATA_W−1)−1], or wrap, according to SAT.
  - Register y_re, y_im and ovf.
  - ovf = 1 if either scaled value lies outside the DATA_W range, in both SAT modes.
- Resulting arithmetic:
  - Normal: y = (XL − YM) + j(XM + YL).
  - conj=1: y = (XL + YM) + j(YL − XM).
- Stall: while out_valid & ~out_ready, y_re, y_im and ovf hold stable and no stage advances. A beat presented with in_ready=0 is not consumed.
- Simultaneous output pop and input push in the same cycle are both legal; the pipeline advances.
- in_valid=0 with en=1 inserts a bubble; stage valid 0 propagates.
- Reset mid-operation discards all in-flight beats; no partial output is produced.
- Data registers of stages holding valid=0 are don't-care. Outputs are qualified by out_valid, but y_re, y_im and ovf are forced to 0 while out_valid=0.

Decomposition:
- Shared package fft_pkg holds:
  - DATA_W/FRAC_W defaults.
  - A rounding-mode enum: RND_TRUNC = 0, RND_HALF_UP = 1.
  - A localparam function computing the internal widths, DATA_W+2 and 2·DATA_W+5.
- One natural sub-module, cmul_round_sat: combinational scale, round and saturate for one component. It takes a (2·DATA_W+5)-bit input and produces a DATA_W-bit output plus an ovf bit. It is instantiated twice in S3.

Test Plan (DATA_W=16, FRAC_W=15, ROUND=1, SAT=1 unless noted):
1. Basic product: X=0x4000, Y=0, L=0x4000, M=0, conj=0 → after 3 cycles, y_re=0x2000, y_im=0x0000, ovf=0.
2. Twiddle −j: X=0x4000, Y=0, L=0, M=0x8000 → y_re=0x0000, y_im=0xC000. Same beat with conj=1 → y_im=0x4000.
3. Saturation: X=Y=L=M=0x8000 → y_re=0x0000, y_im=0x7FFF, ovf=1. With SAT=0 → y_im=0x0000, ovf=1.
4. Rounding: X=1, Y=0, L=0x4000, M=0 → y_re=0x0001 with ROUND=1; y_re=0x0000 with ROUND=0.
5. Backpressure: stream 8 random beats with out_ready toggling 1,0,0,1.
   - Outputs match a golden model in order, with no loss or duplication.
   - y_* are stable while stalled.
   - in_ready = out_ready whenever out_valid=1.
6. Reset mid-stream: assert rst_n=0 with 3 beats in flight → out_valid=0 immediately. After release, the first new beat appears after exactly 3 cycles and no stale data is output.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath: default widths, rounding modes and internal width helpers.
package fft_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned FRAC_W_DEF = 15;

  typedef enum logic {
    RND_TRUNC   = 1'b0,
    RND_HALF_UP = 1'b1
  } rnd_mode_e;

  // Width of the pre-adder results (sum/difference of two sign-extended components).
  function automatic int unsigned pre_w(input int unsigned data_w);
    return data_w + 2;
  endfunction

  // Width of the post-adder results before scaling.
  function automatic int unsigned acc_w(input int unsigned data_w);
    return 2 * data_w + 5;
  endfunction

endpackage

// File: rtl/cmul_round_sat.sv
// Scale one full-precision component down by FRAC_W with optional rounding, then saturate or wrap.
module cmul_round_sat
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned FRAC_W   = FRAC_W_DEF,
  parameter rnd_mode_e   RND_MODE = RND_HALF_UP,
  parameter bit          SAT      = 1'b1
) (
  input  logic signed [acc_w(DATA_W)-1:0] acc_i,
  output logic signed [DATA_W-1:0]        res_c,
  output logic                            ovf_c
);

  localparam int unsigned AW = acc_w(DATA_W);

  localparam logic signed [AW-1:0] RND_K =
    (RND_MODE == RND_HALF_UP) ? AW'(1) << (FRAC_W - 1) : '0;
  localparam logic signed [AW-1:0] MAX_V = {{(AW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [AW-1:0] MIN_V = {{(AW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [AW-1:0] shifted;

  // Round, arithmetic shift, range check and clamp/wrap.
  always_comb begin
    shifted = (acc_i + RND_K) >>> FRAC_W;
    ovf_c   = (shifted > MAX_V) || (shifted < MIN_V);
    res_c   = shifted[DATA_W-1:0];
    if (SAT && ovf_c) begin
      res_c = shifted[AW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/cmul_pipe.sv
// Three-stage Gauss-form complex multiplier (3 real multipliers) with valid/ready and global stall.
module cmul_pipe
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned FRAC_W = FRAC_W_DEF,
  parameter bit          ROUND  = 1'b1,
  parameter bit          SAT    = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     conj,
  input  logic signed [DATA_W-1:0] x_re,
  input  logic signed [DATA_W-1:0] x_im,
  input  logic signed [DATA_W-1:0] w_re,
  input  logic signed [DATA_W-1:0] w_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] y_re,
  output logic signed [DATA_W-1:0] y_im,
  output logic                     ovf
);

  localparam int unsigned W1 = DATA_W + 1;
  localparam int unsigned W2 = pre_w(DATA_W);
  localparam int unsigned PW = 2 * DATA_W + 4;
  localparam int unsigned AW = acc_w(DATA_W);
  localparam rnd_mode_e   RND_MODE = ROUND ? RND_HALF_UP : RND_TRUNC;

  logic en_c;

  // S1: pre-add registers
  logic signed [W1-1:0] x1_q, y1_q, l1_q, x1_d, y1_d, l1_d;
  logic signed [W2-1:0] lm1_q, lp1_q, xy1_q, lm1_d, lp1_d, xy1_d;
  logic signed [W1-1:0] mc_c;
  logic                 v1_q, v1_d;

  // S2: product registers
  logic signed [PW-1:0] t1_q, t2_q, t3_q, t1_d, t2_d, t3_d;
  logic                 v2_q, v2_d;

  // S3: output registers
  logic signed [AW-1:0]     re_c, im_c;
  logic signed [DATA_W-1:0] re_sat_c, im_sat_c;
  logic                     re_ovf_c, im_ovf_c;
  logic signed [DATA_W-1:0] y_re_q, y_im_q, y_re_d, y_im_d;
  logic                     ovf_q, ovf_d, v3_q, v3_d;

  // Global enable: the whole pipe advances whenever the output slot is free or being drained.
  assign en_c     = ~v3_q | out_ready;
  assign in_ready = en_c;

  // S1 next state: sign-extend, apply conjugate to M, form the Gauss pre-sums.
  always_comb begin
    x1_d  = W1'(x_re);
    y1_d  = W1'(x_im);
    l1_d  = W1'(w_re);
    mc_c  = conj ? -W1'(w_im) : W1'(w_im);
    lm1_d = W2'(l1_d) - W2'(mc_c);
    lp1_d = W2'(l1_d) + W2'(mc_c);
    xy1_d = W2'(x1_d) - W2'(y1_d);
    v1_d  = in_valid;
  end

  // S2 next state: three full-precision real products.
  always_comb begin
    t1_d = PW'(lm1_q) * PW'(y1_q);
    t2_d = PW'(lp1_q) * PW'(x1_q);
    t3_d = PW'(l1_q) * PW'(xy1_q);
    v2_d = v1_q;
  end

  // S3 post-add; result is zeroed when the stage carries a bubble.
  always_comb begin
    re_c   = AW'(t1_q) + AW'(t3_q);
    im_c   = AW'(t2_q) - AW'(t3_q);
    y_re_d = v2_q ? re_sat_c : '0;
    y_im_d = v2_q ? im_sat_c : '0;
    ovf_d  = v2_q & (re_ovf_c | im_ovf_c);
    v3_d   = v2_q;
  end

  cmul_round_sat #(
    .DATA_W   (DATA_W),
    .FRAC_W   (FRAC_W),
    .RND_MODE (RND_MODE),
    .SAT      (SAT)
  ) u_rs_re (
    .acc_i (re_c),
    .res_c (re_sat_c),
    .ovf_c (re_ovf_c)
  );

  cmul_round_sat #(
    .DATA_W   (DATA_W),
    .FRAC_W   (FRAC_W),
    .RND_MODE (RND_MODE),
    .SAT      (SAT)
  ) u_rs_im (
    .acc_i (im_c),
    .res_c (im_sat_c),
    .ovf_c (im_ovf_c)
  );

  // Pipeline registers: cleared on reset, loaded only when the pipe is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1_q   <= '0;
      y1_q   <= '0;
      l1_q   <= '0;
      lm1_q  <= '0;
      lp1_q  <= '0;
      xy1_q  <= '0;
      v1_q   <= 1'b0;
      t1_q   <= '0;
      t2_q   <= '0;
      t3_q   <= '0;
      v2_q   <= 1'b0;
      y_re_q <= '0;
      y_im_q <= '0;
      ovf_q  <= 1'b0;
      v3_q   <= 1'b0;
    end else if (en_c) begin
      x1_q   <= x1_d;
      y1_q   <= y1_d;
      l1_q   <= l1_d;
      lm1_q  <= lm1_d;
      lp1_q  <= lp1_d;
      xy1_q  <= xy1_d;
      v1_q   <= v1_d;
      t1_q   <= t1_d;
      t2_q   <= t2_d;
      t3_q   <= t3_d;
      v2_q   <= v2_d;
      y_re_q <= y_re_d;
      y_im_q <= y_im_d;
      ovf_q  <= ovf_d;
      v3_q   <= v3_d;
    end
  end

  assign out_valid = v3_q;
  assign y_re      = y_re_q;
  assign y_im      = y_im_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cmul_pipe.sv
// Bench for cmul_pipe: three instances (default, SAT=0, ROUND=0) share one stimulus stream.
module tb_cmul_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, conj, out_ready;
  logic [15:0] x_re, x_im, w_re, w_im;

  logic        ir [3];
  logic        ov [3];
  logic [15:0] yr [3];
  logic [15:0] yi [3];
  logic        of [3];

  always #5 clk = ~clk;

  // Index 0: ROUND=1 SAT=1, index 1: ROUND=1 SAT=0, index 2: ROUND=0 SAT=1.
  cmul_pipe #(.DATA_W(16), .FRAC_W(15), .ROUND(1'b1), .SAT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .conj(conj),
    .x_re(x_re), .x_im(x_im), .w_re(w_re), .w_im(w_im),
    .out_valid(ov[0]), .out_ready(out_ready), .y_re(yr[0]), .y_im(yi[0]), .ovf(of[0]));

  cmul_pipe #(.DATA_W(16), .FRAC_W(15), .ROUND(1'b1), .SAT(1'b0)) dut_ns (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .conj(conj),
    .x_re(x_re), .x_im(x_im), .w_re(w_re), .w_im(w_im),
    .out_valid(ov[1]), .out_ready(out_ready), .y_re(yr[1]), .y_im(yi[1]), .ovf(of[1]));

  cmul_pipe #(.DATA_W(16), .FRAC_W(15), .ROUND(1'b0), .SAT(1'b1)) dut_tr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .conj(conj),
    .x_re(x_re), .x_im(x_im), .w_re(w_re), .w_im(w_im),
    .out_valid(ov[2]), .out_ready(out_ready), .y_re(yr[2]), .y_im(yi[2]), .ovf(of[2]));

  typedef struct packed {
    logic [2:0][15:0] re;
    logic [2:0][15:0] im;
    logic [2:0]       ovf;
  } exp_t;

  exp_t q[$];
  exp_t head;
  int   checks = 0;
  int   errors = 0;
  bit   bp_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Scale a mathematically exact product by 2^-15, optional half-up rounding, clamp or wrap.
  function automatic void scale(input longint v, input bit rnd, input bit sat,
                                output logic [15:0] r, output logic o);
    longint s;
    s = rnd ? v + 64'sd16384 : v;
    s = s >>> 15;
    o = (s > 64'sd32767) || (s < -64'sd32768);
    if (sat && o) r = (s < 0) ? 16'h8000 : 16'h7fff;
    else          r = s[15:0];
  endfunction

  // Direct complex product, no Gauss decomposition.
  function automatic exp_t model(input logic [15:0] x, y, l, m, input logic c);
    longint xv, yv, lv, mv, re, im;
    logic   o1, o2;
    exp_t   e;
    xv = longint'($signed(x));
    yv = longint'($signed(y));
    lv = longint'($signed(l));
    mv = longint'($signed(m));
    re = c ? xv * lv + yv * mv : xv * lv - yv * mv;
    im = c ? yv * lv - xv * mv : xv * mv + yv * lv;
    e  = '0;
    for (int i = 0; i < 3; i++) begin
      scale(re, i != 2, i != 1, e.re[i], o1);
      scale(im, i != 2, i != 1, e.im[i], o2);
      e.ovf[i] = o1 | o2;
    end
    return e;
  endfunction

  // Scoreboard: record accepted beats, check every output cycle against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("rst out_valid[%0d]", i), 32'(ov[i]), 0);
        chk($sformatf("rst y_re[%0d]", i), 32'(yr[i]), 0);
        chk($sformatf("rst y_im[%0d]", i), 32'(yi[i]), 0);
        chk($sformatf("rst ovf[%0d]", i), 32'(of[i]), 0);
      end
      q.delete();
    end else begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("in_ready[%0d]", i), 32'(ir[i]), 32'(!ov[i] || out_ready));
        if (ov[i]) begin
          chk($sformatf("spurious out[%0d]", i), 32'(q.size() > 0), 1);
          if (q.size() > 0) begin
            head = q[0];
            chk($sformatf("y_re[%0d]", i), 32'(yr[i]), 32'(head.re[i]));
            chk($sformatf("y_im[%0d]", i), 32'(yi[i]), 32'(head.im[i]));
            chk($sformatf("ovf[%0d]", i), 32'(of[i]), 32'(head.ovf[i]));
          end
        end else begin
          chk($sformatf("idle y_re[%0d]", i), 32'(yr[i]), 0);
          chk($sformatf("idle y_im[%0d]", i), 32'(yi[i]), 0);
          chk($sformatf("idle ovf[%0d]", i), 32'(of[i]), 0);
        end
      end
      if (ov[0] && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && ir[0]) q.push_back(model(x_re, x_im, w_re, w_im, conj));
    end
  end

  // Output backpressure pattern 1,0,0,1 while enabled.
  initial begin
    int k;
    logic [3:0] pat;
    k   = 0;
    pat = 4'b1001;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        out_ready = pat[k];
        k = (k + 1) % 4;
      end
    end
  end

  // Present one beat; caller is just after a rising edge. Returns just after the accepting edge.
  task automatic push(input logic [15:0] x, y, l, m, input logic c);
    int n;
    in_valid = 1'b1;
    x_re = x; x_im = y; w_re = l; w_im = m; conj = c;
    n = 0;
    @(negedge clk);
    while (!ir[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ir[0]) chk("push wait", 32'(ir[0]), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Single beat with out_ready=1: check 3-cycle latency and literal default-config results.
  task automatic run_vec(input string nm, input logic [15:0] x, y, l, m, input logic c,
                         input logic [15:0] er, ei, input logic eo);
    int n;
    @(posedge clk);
    #1;
    push(x, y, l, m, c);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ov[0] && n < 20);
    chk({nm, " latency"}, 32'(n), 3);
    chk({nm, " y_re"}, 32'(yr[0]), 32'(er));
    chk({nm, " y_im"}, 32'(yi[0]), 32'(ei));
    chk({nm, " ovf"}, 32'(of[0]), 32'(eo));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; conj = 1'b0; out_ready = 1'b1;
    x_re = '0; x_im = '0; w_re = '0; w_im = '0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready after reset", 32'(ir[0]), 1);
    chk("out_valid after reset", 32'(ov[0]), 0);

    run_vec("basic", 16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 16'h2000, 16'h0000, 1'b0);
    run_vec("twiddle -j", 16'h4000, 16'h0000, 16'h0000, 16'h8000, 1'b0, 16'h0000, 16'hC000, 1'b0);
    run_vec("twiddle conj", 16'h4000, 16'h0000, 16'h0000, 16'h8000, 1'b1, 16'h0000, 16'h4000, 1'b0);
    run_vec("saturate", 16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0, 16'h0000, 16'h7FFF, 1'b1);
    chk("wrap y_re", 32'(yr[1]), 32'h0000);
    chk("wrap y_im", 32'(yi[1]), 32'h0000);
    chk("wrap ovf", 32'(of[1]), 1);
    run_vec("round up", 16'h0001, 16'h0000, 16'h4000, 16'h0000, 1'b0, 16'h0001, 16'h0000, 1'b0);
    chk("trunc y_re", 32'(yr[2]), 32'h0000);
    run_vec("round neg", 16'hFFFF, 16'h0000, 16'h4000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
    chk("trunc neg y_re", 32'(yr[2]), 32'hFFFF);

    // Random stream under backpressure.
    @(posedge clk);
    #1;
    bp_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
    end
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("bp drain", 32'(q.size()), 0);
    bp_en = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Reset with three beats in flight.
    @(posedge clk);
    #1;
    push(16'h1234, 16'h5678, 16'h7000, 16'h9000, 1'b0);
    push(16'h8001, 16'h7FFF, 16'h4000, 16'hC000, 1'b1);
    push(16'h0100, 16'hFF00, 16'h2000, 16'h2000, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 32'(ov[0]), 0);
    chk("async rst y_re", 32'(yr[0]), 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_vec("post reset", 16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 16'h2000, 16'h0000, 1'b0);
    repeat (10) @(negedge clk);
    chk("final queue empty", 32'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
